// File: rtl/mult_seq_if.sv
// mult_seq_if: start/busy/done handshake and operand/result bus
// for the sequential multiply-accumulate unit.
interface mult_seq_if #(
  parameter int WIDTH = 8
);
  logic               start;
  logic [WIDTH-1:0]   A_in;
  logic [WIDTH-1:0]   B_in;
  logic [WIDTH-1:0]   C_in;
  logic [2*WIDTH-1:0] P;
  logic               busy;
  logic               done;
  logic               ovf;

  modport master (
    output start, A_in, B_in, C_in,
    input  P, busy, done, ovf
  );

  modport slave (
    input  start, A_in, B_in, C_in,
    output P, busy, done, ovf
  );
endinterface

// File: rtl/mult_seq.sv
// mult_seq: shift-and-add P = A*B + C, one multiplier bit per clock.
// Optional MULT_EARLY_EXIT_EN stops once remaining multiplier bits are zero.
module mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic      clk,
  input  logic      reset,
  mult_seq_if.slave bus
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [PW-1:0]    mcand;
  logic [PW-1:0]    p;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;
  logic             busy;
  logic             done;
  logic             last;

`ifdef MULT_EARLY_EXIT_EN
  assign last = ((mplier >> 1) == '0) || (cnt == LAST);
`else
  assign last = (cnt == LAST);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      p      <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            mcand  <= PW'(bus.A_in);
            mplier <= bus.B_in;
            p      <= PW'(bus.C_in);
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (mplier[0]) p <= p + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (last) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.P    = p;
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.ovf  = |p[PW-1:WIDTH];
endmodule

// File: tb/tb_mult_seq.sv
// tb_mult_seq: random and directed stimulus against an arithmetic
// model; a done-triggered monitor pops expected results from a queue.
module tb_mult_seq;
  localparam int W = 8;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   exp_q[$];

  mult_seq_if #(.WIDTH(W)) bus ();

  mult_seq #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d @%0t",
               name, act, req, $time);
    end
  endtask

  function automatic int model_lat(input int b);
`ifdef MULT_EARLY_EXIT_EN
    int h;
    h = 0;
    for (int i = 0; i < W; i++)
      if (b[i]) h = i;
    return h + 2;
`else
    return W + 1;
`endif
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset && bus.done) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_done: P=%0d @%0t",
                 bus.P, $time);
      end else begin
        int e;
        e = exp_q.pop_front();
        check("P", 32'(bus.P), 32'(e));
        check("ovf", 32'(bus.ovf), 32'(e >= (1 << W)));
      end
    end
  end

  task automatic do_op(input int a, input int b,
                       input int c, input bit inj);
    int n;
    int bc;
    int le;
    @(negedge clk);
    bus.A_in  = W'(a);
    bus.B_in  = W'(b);
    bus.C_in  = W'(c);
    bus.start = 1'b1;
    exp_q.push_back(a * b + c);
    @(negedge clk);
    bus.start = 1'b0;
    n  = 1;
    bc = 0;
    while (!bus.done && n < 60) begin
      if (bus.busy) bc++;
      if (inj && n == 3) begin
        bus.start = 1'b1;
        bus.A_in  = 8'd9;
        bus.B_in  = 8'd9;
        bus.C_in  = 8'd9;
      end else if (inj && n == 4) begin
        bus.start = 1'b0;
        bus.A_in  = 8'd77;
      end
      @(negedge clk);
      n++;
    end
    if (bus.busy) bc++;
    bus.start = 1'b0;
    le = model_lat(b);
    check("latency", 32'(n), 32'(le));
    check("busy_cycles", 32'(bc), 32'(le));
  endtask

  initial begin
    int a;
    int b;
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.A_in  = '0;
    bus.B_in  = '0;
    bus.C_in  = '0;
    #1;
    check("rst_P", 32'(bus.P), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_ovf", 32'(bus.ovf), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    do_op(13, 11, 2, 1'b0);
    repeat (5) begin
      @(negedge clk);
      check("hold_P", 32'(bus.P), 145);
    end
    do_op(255, 255, 255, 1'b0);
    check("max_ovf_hold", 32'(bus.ovf), 1);
    do_op(200, 0, 7, 1'b0);
    do_op(200, 1, 7, 1'b0);
    do_op(3, 5, 0, 1'b1);
    repeat (12) @(negedge clk);
    check("ignored_P", 32'(bus.P), 15);

    // abort mid-run
    @(negedge clk);
    bus.A_in  = 8'd100;
    bus.B_in  = 8'd100;
    bus.C_in  = 8'd0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
    #1;
    check("abort_P", 32'(bus.P), 0);
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_done", 32'(bus.done), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    do_op(6, 7, 1, 1'b0);

    repeat (30) begin
      do_op($urandom_range(0, 255), $urandom_range(0, 255),
            $urandom_range(0, 255), 1'b0);
    end
    // divider round-trip
    repeat (40) begin
      a = $urandom_range(0, 255);
      b = $urandom_range(1, 255);
      do_op(a / b, b, a % b, 1'b0);
      check("rt_P", 32'(bus.P), 32'(a));
      check("rt_ovf", 32'(bus.ovf), 0);
    end
    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mult_seq.md
Name: mult_seq

Overview:
- Sequential shift-and-add multiply-accumulate unit: P = A*B + C, one multiplier bit per clock.
- Inverse of the divider. Feeding it the quotient, divisor and remainder rebuilds the dividend, which supports self-check of the divider.
- Also a standalone multiplier for the arithmetic block set.
- Start/busy/done handshake driven by a 3-state FSM.

Parameters:
- WIDTH, 8, operand width; product/result width is 2*WIDTH.

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  asynchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- A_in  input  WIDTH  multiplicand (e.g. quotient).
- B_in  input  WIDTH  multiplier (e.g. divisor).
- C_in  input  WIDTH  addend (e.g. remainder).
- P  output  2*WIDTH  result, registered.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse, result valid.
- ovf  output  1  high when P[2*WIDTH-1:WIDTH] != 0, i.e. the result does not fit in WIDTH bits.

Behaviour:
- Clock and reset: reset reset, asynchronous, active-high; clock clk.
- Reset values: state=IDLE; P, busy, done and ovf all 0; internal registers (mcand, mplier, cnt) all 0.
- Reset asserted mid-operation aborts the operation immediately to the reset values. No done pulse is produced.
- Internal registers:
  - mcand: 2*WIDTH bits.
  - mplier: WIDTH bits.
  - cnt: clog2(WIDTH) bits.
- IDLE:
  - On start=1: mcand <= zero-extended A_in; mplier <= B_in; P <= zero-extended C_in; cnt <= 0; go to RUN.
  - Inputs are sampled only on this edge. Changes to A_in/B_in/C_in afterwards have no effect.
- RUN, each cycle:
  - If mplier[0]: P <= P + mcand (2*WIDTH-bit add, no carry out possible).
  - mcand <= mcand << 1; mplier <= mplier >> 1; cnt <= cnt + 1.
  - When cnt == WIDTH-1, go to DONE. This gives exactly WIDTH RUN cycles.
- DONE:
  - done=1 for exactly one cycle; then go to IDLE.
  - start is ignored in DONE and in RUN; no queuing.
- Latency: start sampled at edge 0; RUN occupies edges 1..WIDTH; done is high in the cycle following edge WIDTH. For WIDTH=8 that is 9 cycles from start to done.
- P and ovf hold their values after done until the next accepted start.
- ovf is combinational from P. It is only meaningful when done=1 or in IDLE after completion.
- Range: the maximum result is (2^W-1)^2 + (2^W-1) = 2^(2W) - 2^W, so 2*WIDTH bits never wrap.
- A_in=0 or B_in=0: full latency still applies (unless the optional feature is enabled); P=C_in.
- busy = (state != IDLE).
- done and busy are registered/state-decoded with no combinational path from start.

Optional Feature:
- Macro: MULT_EARLY_EXIT_EN.
- Defined:
  - In RUN, go to DONE when the next mplier (mplier >> 1) == 0 or cnt == WIDTH-1, whichever comes first.
  - With highest set bit h of B_in, done is high after edge h+1.
  - B_in=0 and B_in=1 both finish after edge 1 (done 2 cycles after start).
  - Results are identical to the full-latency mode.
- Undefined: fixed latency of WIDTH RUN cycles regardless of operands.

Test Plan:
- A=13, B=11, C=2, pulse start -> busy=1 for 9 cycles, done pulse after edge 8, P=145 (0x0091), ovf=0; P holds 145 for 5 further cycles.
- A=255, B=255, C=255 -> P=0xFF00 (65280), ovf=1.
- A=200, B=0, C=7 -> P=7, ovf=0. Without the macro, done after edge 8; with MULT_EARLY_EXIT_EN, done after edge 1.
- Start A=3, B=5, C=0. At cycle 3 pulse start with A=9, B=9, C=9 and change A_in -> the second start is ignored; P=15 at done; no second done.
- Start A=100, B=100, C=0; assert reset at RUN cycle 4 -> P=0, busy=0, done=0 immediately, and no done follows. After release, start A=6, B=7, C=1 -> P=43.
- Divider round-trip: for all A in 0..255, B in 1..255 (sampled), feed divider Q, B, R into A_in, B_in, C_in -> P == A, ovf=0.
